// File: rtl/adc_chan_avg.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// adc_chan_avg
//
// Block-averaging stage behind the 8-channel SPI ADC converter. It counts the
// converter's per-conversion finish strobes. At the end of every complete scan
// sweep it snapshots all eight channel values. Each channel is summed over
// 2^AVG_LOG2 accepted sweeps. The block then publishes the truncated
// per-channel averages, a one-cycle valid strobe and per-channel
// high-threshold alarms.
//
// A short state machine serialises the accumulation: IDLE waits for a sweep
// completion, ACC adds one channel per cycle (8 cycles), and DUMP publishes
// the block result. A sweep that completes while ACC or DUMP is still busy
// is discarded and flagged on the sticky overrun output.
//
// Parameters
//   AVG_LOG2   log2 of sweeps per average, 0..6
//   SWEEP_LEN  finish_in pulses per scan sweep, 1..8
//   HI_THR     alarm threshold; alarm when average > HI_THR
//
// Ports
//   clk                      system clock
//   rst_n                    asynchronous active-low reset
//   value_in0..value_in7     converter channel results, unsigned 12 bit
//   finish_in                one-cycle strobe per conversion
//   avg_out0..avg_out7       last published averages (registered)
//   avg_valid                one-cycle pulse when avg_out*/alarm_hi update
//   alarm_hi                 bit i set when avg_out i > HI_THR
//   overrun                  sticky: a sweep completed while the block was busy
// -----------------------------------------------------------------------------
module adc_chan_avg #(
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned SWEEP_LEN = 8,
  parameter logic [11:0] HI_THR    = 12'd3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] value_in0,
  input  logic [11:0] value_in1,
  input  logic [11:0] value_in2,
  input  logic [11:0] value_in3,
  input  logic [11:0] value_in4,
  input  logic [11:0] value_in5,
  input  logic [11:0] value_in6,
  input  logic [11:0] value_in7,
  input  logic        finish_in,
  output logic [11:0] avg_out0,
  output logic [11:0] avg_out1,
  output logic [11:0] avg_out2,
  output logic [11:0] avg_out3,
  output logic [11:0] avg_out4,
  output logic [11:0] avg_out5,
  output logic [11:0] avg_out6,
  output logic [11:0] avg_out7,
  output logic        avg_valid,
  output logic [7:0]  alarm_hi,
  output logic        overrun
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // The accumulator holds 2^AVG_LOG2 full-scale samples without overflow.
  localparam int unsigned ACC_W = 12 + AVG_LOG2;
  // One extra bit keeps the block counter non-zero width when AVG_LOG2 = 0.
  localparam int unsigned BLK_W = AVG_LOG2 + 1;

  localparam logic [2:0]       SWEEP_LAST = 3'(SWEEP_LEN - 1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'((1 << AVG_LOG2) - 1);

  // Elaboration-time guard against illegal configurations.
  if (AVG_LOG2 > 6) begin : g_bad_avg_log2
    $error("adc_chan_avg: AVG_LOG2 must be in 0..6");
  end
  if (SWEEP_LEN < 1 || SWEEP_LEN > 8) begin : g_bad_sweep_len
    $error("adc_chan_avg: SWEEP_LEN must be in 1..8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DUMP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [2:0]       sweep_cnt;
  logic [2:0]       idx;
  logic [BLK_W-1:0] blk_cnt;
  logic [11:0]      snap    [8];
  logic [ACC_W-1:0] acc     [8];
  logic [11:0]      avg     [8];

  logic [11:0]      value_in [8];
  logic [11:0]      acc_avg  [8];
  logic             sweep_done;

  assign value_in[0] = value_in0;
  assign value_in[1] = value_in1;
  assign value_in[2] = value_in2;
  assign value_in[3] = value_in3;
  assign value_in[4] = value_in4;
  assign value_in[5] = value_in5;
  assign value_in[6] = value_in6;
  assign value_in[7] = value_in7;

  assign avg_out0 = avg[0];
  assign avg_out1 = avg[1];
  assign avg_out2 = avg[2];
  assign avg_out3 = avg[3];
  assign avg_out4 = avg[4];
  assign avg_out5 = avg[5];
  assign avg_out6 = avg[6];
  assign avg_out7 = avg[7];

  // The pulse that wraps the sweep counter marks the sweep completion.
  assign sweep_done = finish_in && (sweep_cnt == SWEEP_LAST);

  // Truncated average of each accumulator: drop the AVG_LOG2 fraction bits.
  // NOTE: every element is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      acc_avg[i] = acc[i][AVG_LOG2 +: 12];
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep counter: counts every finish strobe regardless of state, so sweep
  // boundaries stay aligned with the converter even while sweeps are dropped.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
    end else if (finish_in) begin
      sweep_cnt <= (sweep_cnt == SWEEP_LAST) ? 3'd0 : sweep_cnt + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  //   IDLE : wait for a sweep completion, capture the snapshot.
  //   ACC  : acc[idx] += snap[idx] for idx 0..7, one channel per cycle.
  //   DUMP : publish averages and alarms, clear the accumulators.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      blk_cnt   <= '0;
      avg_valid <= 1'b0;
      alarm_hi  <= '0;
      overrun   <= 1'b0;
      // NOTE: these arrays are small register banks, not RAM, and a reset
      // must abandon any partial average, so they are cleared here.
      for (int i = 0; i < 8; i++) begin
        snap[i] <= '0;
        acc[i]  <= '0;
        avg[i]  <= '0;
      end
    end else begin
      // Strobe is high only in the cycle after DUMP.
      avg_valid <= 1'b0;

      // A completion while busy is dropped; the flag stays set until reset.
      if (sweep_done && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (sweep_done) begin
            for (int i = 0; i < 8; i++) begin
              snap[i] <= value_in[i];
            end
            idx   <= 3'd0;
            state <= ACC;
          end
        end

        ACC: begin
          acc[idx] <= acc[idx] + ACC_W'(snap[idx]);
          idx      <= idx + 3'd1;
          if (idx == 3'd7) begin
            if (blk_cnt == BLK_LAST) begin
              state <= DUMP;
            end else begin
              blk_cnt <= blk_cnt + BLK_W'(1);
              state   <= IDLE;
            end
          end
        end

        DUMP: begin
          for (int i = 0; i < 8; i++) begin
            avg[i]      <= acc_avg[i];
            alarm_hi[i] <= (acc_avg[i] > HI_THR);
            acc[i]      <= '0;
          end
          avg_valid <= 1'b1;
          blk_cnt   <= '0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adc_chan_avg.md
# adc_chan_avg

Block-averaging stage directly downstream of the 8-channel SPI ADC converter. It counts the converter's per-conversion `finish` strobes and snapshots all eight channel values at the end of every complete scan sweep. It accumulates each channel over 2^AVG_LOG2 sweeps and publishes truncated per-channel averages with a one-cycle valid strobe and per-channel high-threshold alarms. It feeds the slow-control/telemetry logic, which reads averages only on `avg_valid`.

## Interface
- AVG_LOG2, 2: log2 of sweeps per average; legal 0..6.
- SWEEP_LEN, 8: `finish_in` pulses per scan sweep; equals converter channel count (chn_end-chn_str+1); legal 1..8.
- HI_THR, 12'd3000: alarm threshold; alarm when average > HI_THR (strict).
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- value_in0..value_in7  in  12 each  converter channel results, unsigned.
- finish_in  in  1  one-cycle strobe, high in the same cycle a new value_inN becomes visible.
- avg_out0..avg_out7  out  12 each  last published averages, registered.
- avg_valid  out  1  one-cycle pulse; avg_out*/alarm_hi updated in the same cycle.
- alarm_hi  out  8  bit i = (avg_out i > HI_THR); updated only with avg_valid.
- overrun  out  1  sticky; a sweep completed while the accumulate pass was busy.

## Operation
- Reset (asynchronous, rst_n=0): all avg_out*=0, avg_valid=0, alarm_hi=0, overrun=0; accumulators, snapshot, sweep count, block count=0; state IDLE. Release takes effect on the next clk edge.
- Sweep counter: increments on every finish_in=1, in every state; wraps from SWEEP_LEN-1 to 0. The pulse that wraps it is the sweep completion.
- Sweep completion in IDLE: copy value_in0..7 into snapshot regs on that same edge; go to ACC with idx=0.
- Sweep completion outside IDLE: snapshot untouched; sweep discarded (not accumulated, block count unchanged); overrun<=1. overrun clears only on reset.
- ACC (8 cycles, idx 0..7): acc[idx] <= acc[idx] + snap[idx]; after idx=7, go to DUMP if blk_cnt == 2^AVG_LOG2-1, else blk_cnt++ and return to IDLE.
- DUMP (1 cycle): for all i, avg_out i <= acc[i][AVG_LOG2+11:AVG_LOG2]. Truncation, no rounding. alarm_hi[i] <= (that value > HI_THR); avg_valid<=1; all acc<=0; blk_cnt<=0; go to IDLE.
- Accumulator width 12+AVG_LOG2 bits; 2^AVG_LOG2 × 4095 never overflows.
- AVG_LOG2=0: every sweep dumps; avg_out equals the snapshot.
- avg_valid is forced 0 in every cycle other than the one after DUMP.
- Values of value_in* between completions are ignored; only the snapshot is used.

## Timing
- E0 = edge sampling the completing finish_in.
- ACC occupies edges E1..E8.
- DUMP edge E9 writes avg_out*, alarm_hi, avg_valid=1; avg_valid returns to 0 at E10.
- Non-dump sweep: back in IDLE after E8; the next completion is accepted from E9 on.
- Busy window (overrun-sensitive): completions sampled at edges E1..E9 inclusive. The converter spaces finish pulses by ≥100 cycles, so overrun indicates an upstream fault.
- Reset mid-ACC/DUMP: abandons the partial average; no avg_valid is generated; the first post-reset average needs 2^AVG_LOG2 full sweeps.

## Test plan
- Constant inputs: AVG_LOG2=2, value_in i = 100·i, pulse finish_in every 200 cycles. After 32 pulses -> exactly one avg_valid, 9 cycles after the 32nd pulse's edge; avg_out i = 100·i; alarm_hi=0; overrun=0.
- Truncation: ch0 snapshots 1,2,3,4 over 4 sweeps -> avg_out0=2 (10>>2). Full-scale 4095 on ch7 for 4 sweeps -> avg_out7=4095, alarm_hi[7]=1; the next block of 2900 -> alarm_hi[7]=0.
- Threshold edge: averages exactly 3000 and 3001 -> alarm bit 0 and 1 respectively.
- Overrun: a completion at E0, then 8 finish pulses on consecutive cycles starting E1 -> overrun=1 and stays 1. That sweep is excluded: the average equals the mean of the accepted sweeps, and avg_valid arrives one sweep later.
- Reset mid-ACC: assert rst_n=0 at E4 of the 4th sweep -> all outputs 0 immediately, no avg_valid. After release, the next avg_valid follows 32 further finish pulses.
- AVG_LOG2=0, SWEEP_LEN=4: avg_valid every 4th pulse; avg_out i equals value_in i at that pulse.
